// File: rtl/pc_sequencer_pkg.sv
// Shared types for the program-counter sequencer: PC select codes, decoded
// control ops, branch conditions and the sequencer state encoding.
package pc_sequencer_pkg;

  // Select code consumed by the pc block's ps_in.
  typedef enum logic [1:0] {
    PC_NOP = 2'd0,
    PC_INC = 2'd1,
    PC_BRA = 2'd2,
    PC_JMP = 2'd3
  } pc_t;

  typedef enum logic [1:0] {
    OP_SEQ = 2'd0,
    OP_BRA = 2'd1,
    OP_JMP = 2'd2,
    OP_HLT = 2'd3
  } ctrl_op_t;

  typedef enum logic [1:0] {
    BC_ALW = 2'd0,
    BC_Z   = 2'd1,
    BC_NZ  = 2'd2,
    BC_N   = 2'd3
  } br_cond_t;

  typedef enum logic [1:0] {
    StFetch  = 2'd0,
    StDecode = 2'd1,
    StExec   = 2'd2,
    StHalt   = 2'd3
  } seq_state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle of the sequencer's imem handshake, decoder inputs, ALU flags and
// pc-block / status outputs. master = sequencer side, slave = environment side.
interface pc_sequencer_if
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) ();

  logic             fetch_req;
  logic             fetch_ack;
  logic             ir_load;
  logic             dec_valid;
  ctrl_op_t         dec_op;
  br_cond_t         br_cond;
  logic             stall_in;
  logic             z_in;
  logic             n_in;
  logic             resume;
  pc_t              ps_out;
  logic             halted;
  logic             fetch_err;
  logic [CNT_W-1:0] instr_count;

  modport master (
    output fetch_req, ir_load, ps_out, halted, fetch_err, instr_count,
    input  fetch_ack, dec_valid, dec_op, br_cond, stall_in, z_in, n_in, resume
  );

  modport slave (
    input  fetch_req, ir_load, ps_out, halted, fetch_err, instr_count,
    output fetch_ack, dec_valid, dec_op, br_cond, stall_in, z_in, n_in, resume
  );

endinterface

// File: rtl/pc_sequencer_branch_cond_eval.sv
// Combinational branch-taken evaluation from a branch condition and ALU flags.
module pc_sequencer_branch_cond_eval
  import pc_sequencer_pkg::*;
(
  input  br_cond_t cond,
  input  logic     z,
  input  logic     n,
  output logic     taken
);

  // Select the flag (or constant) that decides the branch.
  always_comb begin
    taken = 1'b0;
    unique case (cond)
      BC_ALW:  taken = 1'b1;
      BC_Z:    taken = z;
      BC_NZ:   taken = ~z;
      BC_N:    taken = n;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetch -> decode -> execute control FSM with fetch
// timeout, halt/resume and a saturating retired-instruction counter.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned FETCH_TIMEOUT = 16,
  parameter int unsigned CNT_W         = 16
) (
  input logic             clk,
  input logic             rst_n,
  pc_sequencer_if.master  bus
);

  localparam int unsigned WaitW = (FETCH_TIMEOUT > 0) ? $clog2(FETCH_TIMEOUT + 1) : 1;
  localparam bit TimeoutEn = (FETCH_TIMEOUT != 0);
  localparam logic [WaitW-1:0] WaitLimit = WaitW'(FETCH_TIMEOUT);
  localparam logic [CNT_W-1:0] CntMax = '1;

  seq_state_t       state_q;
  ctrl_op_t         op_q;
  br_cond_t         cond_q;
  logic [WaitW-1:0] wait_cnt_q;
  logic             fetch_err_q;
  logic [CNT_W-1:0] count_q;

  logic taken;
  logic fetch_req;
  logic ir_load;
  logic halted;
  pc_t  ps;

  pc_sequencer_branch_cond_eval u_bce (
    .cond  (cond_q),
    .z     (bus.z_in),
    .n     (bus.n_in),
    .taken (taken)
  );

  // State machine, fetch wait counter, sticky error and retired counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StFetch;
      op_q        <= OP_SEQ;
      cond_q      <= BC_ALW;
      wait_cnt_q  <= '0;
      fetch_err_q <= 1'b0;
      count_q     <= '0;
    end else begin
      unique case (state_q)
        StFetch: begin
          if (bus.fetch_ack) begin
            state_q    <= StDecode;
            wait_cnt_q <= '0;
          end else if (TimeoutEn && (wait_cnt_q == WaitLimit)) begin
            state_q     <= StHalt;
            fetch_err_q <= 1'b1;
            wait_cnt_q  <= '0;
          end else if (TimeoutEn) begin
            wait_cnt_q <= wait_cnt_q + WaitW'(1);
          end
        end
        StDecode: begin
          // A hazard stall holds the op back even when the decoder is valid.
          if (bus.dec_valid && !bus.stall_in) begin
            op_q    <= bus.dec_op;
            cond_q  <= bus.br_cond;
            state_q <= StExec;
          end
        end
        StExec: begin
          if (count_q != CntMax) begin
            count_q <= count_q + CNT_W'(1);
          end
          wait_cnt_q <= '0;
          state_q    <= (op_q == OP_HLT) ? StHalt : StFetch;
        end
        StHalt: begin
          if (bus.resume) begin
            fetch_err_q <= 1'b0;
            wait_cnt_q  <= '0;
            state_q     <= StFetch;
          end
        end
        default: begin
          wait_cnt_q <= '0;
          state_q    <= StFetch;
        end
      endcase
    end
  end

  // Outputs decoded from state; forced quiet while reset is asserted so the
  // pc block never sees a partial update.
  always_comb begin
    fetch_req = 1'b0;
    ir_load   = 1'b0;
    halted    = 1'b0;
    ps        = PC_NOP;
    if (rst_n) begin
      unique case (state_q)
        StFetch: begin
          fetch_req = 1'b1;
          ir_load   = bus.fetch_ack;
        end
        StExec: begin
          unique case (op_q)
            OP_SEQ:  ps = PC_INC;
            OP_BRA:  ps = taken ? PC_BRA : PC_INC;
            OP_JMP:  ps = PC_JMP;
            default: ps = PC_NOP;
          endcase
        end
        StHalt: begin
          halted = 1'b1;
          // Step past the halting or faulting word on the way out.
          if (bus.resume) begin
            ps = PC_INC;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.fetch_req   = fetch_req;
  assign bus.ir_load     = ir_load;
  assign bus.halted      = halted;
  assign bus.ps_out      = ps;
  assign bus.fetch_err   = fetch_err_q;
  assign bus.instr_count = count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: one instance with a short fetch timeout and
// narrow counter, one with the timeout disabled and its fetch_ack held low.
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  pc_sequencer_if #(.CNT_W(4))  bus_a ();
  pc_sequencer_if #(.CNT_W(16)) bus_b ();

  pc_sequencer #(.FETCH_TIMEOUT(4), .CNT_W(4)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a.master)
  );

  pc_sequencer #(.FETCH_TIMEOUT(0), .CNT_W(16)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b.master)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One instruction with an immediate ack; starts and ends just after a rising edge.
  task automatic run_instr(input string tag, input ctrl_op_t op, input br_cond_t cond,
                           input logic z, input logic n, input pc_t exp_ps);
    bus_a.fetch_ack = 1'b1;
    @(negedge clk);
    check_eq({tag, "_fetch_req"}, 32'(bus_a.fetch_req), 32'd1);
    check_eq({tag, "_ir_load"}, 32'(bus_a.ir_load), 32'd1);
    next_cycle();
    bus_a.fetch_ack = 1'b0;
    bus_a.dec_valid = 1'b1;
    bus_a.dec_op    = op;
    bus_a.br_cond   = cond;
    @(negedge clk);
    check_eq({tag, "_ps_decode"}, 32'(bus_a.ps_out), 32'd0);
    next_cycle();
    bus_a.dec_valid = 1'b0;
    bus_a.z_in      = z;
    bus_a.n_in      = n;
    @(negedge clk);
    check_eq({tag, "_ps_exec"}, 32'(bus_a.ps_out), 32'(exp_ps));
    next_cycle();
    bus_a.z_in = 1'b0;
    bus_a.n_in = 1'b0;
  endtask

  initial begin
    rst_n           = 1'b0;
    bus_a.fetch_ack = 1'b1;
    bus_a.dec_valid = 1'b0;
    bus_a.dec_op    = OP_SEQ;
    bus_a.br_cond   = BC_ALW;
    bus_a.stall_in  = 1'b0;
    bus_a.z_in      = 1'b0;
    bus_a.n_in      = 1'b0;
    bus_a.resume    = 1'b0;
    bus_b.fetch_ack = 1'b0;
    bus_b.dec_valid = 1'b0;
    bus_b.dec_op    = OP_SEQ;
    bus_b.br_cond   = BC_ALW;
    bus_b.stall_in  = 1'b0;
    bus_b.z_in      = 1'b0;
    bus_b.n_in      = 1'b0;
    bus_b.resume    = 1'b0;

    // Outputs quiet in reset, even with fetch_ack high.
    @(negedge clk);
    check_eq("rst_fetch_req", 32'(bus_a.fetch_req), 32'd0);
    check_eq("rst_ir_load", 32'(bus_a.ir_load), 32'd0);
    check_eq("rst_ps", 32'(bus_a.ps_out), 32'd0);
    check_eq("rst_halted", 32'(bus_a.halted), 32'd0);
    check_eq("rst_fetch_err", 32'(bus_a.fetch_err), 32'd0);
    check_eq("rst_count", 32'(bus_a.instr_count), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Basic sequencing and branch conditions.
    run_instr("seq", OP_SEQ, BC_ALW, 1'b0, 1'b0, PC_INC);
    check_eq("seq_count", 32'(bus_a.instr_count), 32'd1);
    run_instr("bra_z1", OP_BRA, BC_Z, 1'b1, 1'b0, PC_BRA);
    run_instr("bra_z0", OP_BRA, BC_Z, 1'b0, 1'b0, PC_INC);
    run_instr("bra_n1", OP_BRA, BC_N, 1'b0, 1'b1, PC_BRA);
    run_instr("bra_nz", OP_BRA, BC_NZ, 1'b0, 1'b0, PC_BRA);
    run_instr("bra_alw", OP_BRA, BC_ALW, 1'b0, 1'b0, PC_BRA);
    run_instr("jmp", OP_JMP, BC_ALW, 1'b0, 1'b0, PC_JMP);
    run_instr("hlt", OP_HLT, BC_ALW, 1'b0, 1'b0, PC_NOP);

    // Halted; stray ack/valid must not move the FSM.
    bus_a.fetch_ack = 1'b1;
    bus_a.dec_valid = 1'b1;
    @(negedge clk);
    check_eq("halt_halted", 32'(bus_a.halted), 32'd1);
    check_eq("halt_fetch_req", 32'(bus_a.fetch_req), 32'd0);
    check_eq("halt_ir_load", 32'(bus_a.ir_load), 32'd0);
    check_eq("halt_ps", 32'(bus_a.ps_out), 32'd0);
    check_eq("halt_count", 32'(bus_a.instr_count), 32'd8);
    next_cycle();
    bus_a.fetch_ack = 1'b0;
    bus_a.dec_valid = 1'b0;
    bus_a.resume    = 1'b1;
    @(negedge clk);
    check_eq("resume_ps", 32'(bus_a.ps_out), 32'd1);
    check_eq("resume_halted_same", 32'(bus_a.halted), 32'd1);
    next_cycle();
    bus_a.resume = 1'b0;
    @(negedge clk);
    check_eq("resume_halted_next", 32'(bus_a.halted), 32'd0);
    check_eq("resume_fetch_req", 32'(bus_a.fetch_req), 32'd1);

    // Fetch timeout: wait counts 0..4 in FETCH, then HALT with error.
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_eq("to_wait_fetch_req", 32'(bus_a.fetch_req), 32'd1);
    check_eq("to_wait_halted", 32'(bus_a.halted), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check_eq("to_halted", 32'(bus_a.halted), 32'd1);
    check_eq("to_fetch_err", 32'(bus_a.fetch_err), 32'd1);
    check_eq("to_ps", 32'(bus_a.ps_out), 32'd0);
    next_cycle();
    bus_a.resume = 1'b1;
    @(negedge clk);
    check_eq("to_resume_ps", 32'(bus_a.ps_out), 32'd1);
    check_eq("to_err_held", 32'(bus_a.fetch_err), 32'd1);
    next_cycle();
    bus_a.resume = 1'b0;
    @(negedge clk);
    check_eq("to_err_clr", 32'(bus_a.fetch_err), 32'd0);
    check_eq("to_refetch", 32'(bus_a.fetch_req), 32'd1);
    check_eq("to_count", 32'(bus_a.instr_count), 32'd8);
    next_cycle();

    // Stall holds DECODE with dec_valid high.
    bus_a.fetch_ack = 1'b1;
    @(negedge clk);
    check_eq("stall_ir_load", 32'(bus_a.ir_load), 32'd1);
    next_cycle();
    bus_a.fetch_ack = 1'b0;
    bus_a.dec_valid = 1'b1;
    bus_a.stall_in  = 1'b1;
    bus_a.dec_op    = OP_SEQ;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("stall_ps", 32'(bus_a.ps_out), 32'd0);
      check_eq("stall_fetch_req", 32'(bus_a.fetch_req), 32'd0);
      next_cycle();
    end
    bus_a.stall_in = 1'b0;
    @(negedge clk);
    check_eq("unstall_ps_decode", 32'(bus_a.ps_out), 32'd0);
    next_cycle();
    bus_a.dec_valid = 1'b0;
    @(negedge clk);
    check_eq("unstall_ps_exec", 32'(bus_a.ps_out), 32'd1);
    next_cycle();
    check_eq("unstall_count", 32'(bus_a.instr_count), 32'd9);

    // Reset asserted in the middle of EXEC.
    bus_a.fetch_ack = 1'b1;
    next_cycle();
    bus_a.fetch_ack = 1'b0;
    bus_a.dec_valid = 1'b1;
    bus_a.dec_op    = OP_JMP;
    next_cycle();
    bus_a.dec_valid = 1'b0;
    @(negedge clk);
    check_eq("rexec_ps_before", 32'(bus_a.ps_out), 32'd3);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("rexec_ps", 32'(bus_a.ps_out), 32'd0);
    check_eq("rexec_fetch_req", 32'(bus_a.fetch_req), 32'd0);
    check_eq("rexec_count", 32'(bus_a.instr_count), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rexec_state_fetch", 32'(bus_a.fetch_req), 32'd1);
    check_eq("rexec_halted", 32'(bus_a.halted), 32'd0);
    check_eq("rexec_count_after", 32'(bus_a.instr_count), 32'd0);
    next_cycle();

    // Stray resume/dec_valid in FETCH without ack: no effect.
    bus_a.resume    = 1'b1;
    bus_a.dec_valid = 1'b1;
    @(negedge clk);
    check_eq("stray_ps", 32'(bus_a.ps_out), 32'd0);
    check_eq("stray_halted", 32'(bus_a.halted), 32'd0);
    next_cycle();
    bus_a.resume    = 1'b0;
    bus_a.dec_valid = 1'b0;
    @(negedge clk);
    check_eq("stray_fetch_req", 32'(bus_a.fetch_req), 32'd1);
    check_eq("stray_ir_load", 32'(bus_a.ir_load), 32'd0);
    next_cycle();

    // Counter saturation at 15 with a 4-bit counter.
    for (int i = 1; i <= 17; i++) begin
      run_instr("sat", OP_SEQ, BC_ALW, 1'b0, 1'b0, PC_INC);
      check_eq("sat_count", 32'(bus_a.instr_count), (i < 15) ? 32'(i) : 32'd15);
    end

    // Timeout disabled: still fetching, no error, long after 16 idle cycles.
    @(negedge clk);
    check_eq("noto_fetch_req", 32'(bus_b.fetch_req), 32'd1);
    check_eq("noto_halted", 32'(bus_b.halted), 32'd0);
    check_eq("noto_fetch_err", 32'(bus_b.fetch_err), 32'd0);
    check_eq("noto_count", 32'(bus_b.instr_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
